bus_cycle_sequencer: RTL and testbench

//  Sequences every CPU memory access onto the shared, time-multiplexed pin bus (uo_out / uio_*).

---
 rtl/bus_cycle_sequencer.sv | 178 +++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: arbitrates fetch and data requests
// and runs each access as ADDR_LO, ADDR_HI, DATA on the pin bus.
module bus_cycle_sequencer #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_done,
    input  logic        mem_req,
    input  logic [15:0] mem_addr,
    input  logic        mem_we,
    input  logic [7:0]  mem_wdata,
    output logic        mem_gnt,
    output logic        mem_done,
    output logic [7:0]  rdata,
    output logic        bus_err,
    input  logic        bus_rdy,
    output logic [7:0]  bus_uo,
    output logic [7:0]  bus_uio_out,
    output logic [7:0]  bus_uio_oe,
    input  logic [7:0]  bus_uio_in,
    output logic [1:0]  bus_phase
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ALO  = 2'd1;
    localparam logic [1:0] S_AHI  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        sel_q, sel_d;
    logic        rr_q, rr_d;
    logic [7:0]  wait_q, wait_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        fdone_q, fdone_d;
    logic        mdone_q, mdone_d;
    logic        err_q, err_d;
    logic        fgnt_q, fgnt_d;
    logic        mgnt_q, mgnt_d;
    logic        pick_mem;
    logic        finish;

    // rr_q=1 means mem was granted last, so a tie goes to fetch
    assign pick_mem = mem_req && (!fetch_req || !rr_q);

    // Next-state logic: arbitration, phase sequencing, wait timeout
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        fgnt_d  = fgnt_q;
        mgnt_d  = mgnt_q;
        fdone_d = 1'b0;
        mdone_d = 1'b0;
        err_d   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fetch_req || mem_req) begin
                    sel_d   = pick_mem;
                    rr_d    = pick_mem;
                    addr_d  = pick_mem ? mem_addr : fetch_addr;
                    we_d    = pick_mem & mem_we;
                    wdata_d = pick_mem ? mem_wdata : 8'h00;
                    fgnt_d  = !pick_mem;
                    mgnt_d  = pick_mem;
                    state_d = S_ALO;
                end
            end
            S_ALO: state_d = S_AHI;
            S_AHI: begin
                wait_d  = 8'd0;
                state_d = S_DATA;
            end
            default: begin
                if (bus_rdy) begin
                    if (!we_q) rdata_d = bus_uio_in;
                    finish = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    if (!we_q) rdata_d = 8'hFF;
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
        if (finish) begin
            fdone_d = !sel_q;
            mdone_d = sel_q;
            fgnt_d  = 1'b0;
            mgnt_d  = 1'b0;
            state_d = S_IDLE;
        end
    end

    // State and bookkeeping registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            sel_q   <= 1'b0;
            rr_q    <= 1'b1;
            wait_q  <= 8'd0;
            rdata_q <= 8'h00;
            fdone_q <= 1'b0;
            mdone_q <= 1'b0;
            err_q   <= 1'b0;
            fgnt_q  <= 1'b0;
            mgnt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            fdone_q <= fdone_d;
            mdone_q <= mdone_d;
            err_q   <= err_d;
            fgnt_q  <= fgnt_d;
            mgnt_q  <= mgnt_d;
        end
    end

    // Pin drive decoded from registered state only
    always_comb begin
        bus_uo      = 8'h00;
        bus_uio_out = 8'h00;
        bus_uio_oe  = 8'h00;
        case (state_q)
            S_ALO: begin
                bus_uo      = addr_q[7:0];
                bus_uio_out = {7'b0, we_q};
                bus_uio_oe  = 8'h01;
            end
            S_AHI: begin
                bus_uo      = addr_q[15:8];
                bus_uio_out = {7'b0, we_q};
                bus_uio_oe  = 8'h01;
            end
            S_DATA: begin
                bus_uo = addr_q[7:0];
                if (we_q) begin
                    bus_uio_out = wdata_q;
                    bus_uio_oe  = 8'hFF;
                end
            end
            default: ;
        endcase
    end

    assign bus_phase  = state_q;
    assign fetch_gnt  = fgnt_q;
    assign mem_gnt    = mgnt_q;
    assign fetch_done = fdone_q;
    assign mem_done   = mdone_q;
    assign bus_err    = err_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed bench for bus_cycle_sequencer with
// hand-computed expected phases, pins and handshakes.
module tb_bus_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_done;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        mem_gnt;
    logic        mem_done;
    logic [7:0]  rdata;
    logic        bus_err;
    logic        bus_rdy;
    logic [7:0]  bus_uo;
    logic [7:0]  bus_uio_out;
    logic [7:0]  bus_uio_oe;
    logic [7:0]  bus_uio_in;
    logic [1:0]  bus_phase;

    int checks   = 0;
    int failures = 0;

    bus_cycle_sequencer #(.WAIT_MAX(16)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt),
        .fetch_done(fetch_done),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt),
        .mem_done(mem_done),
        .rdata(rdata),
        .bus_err(bus_err),
        .bus_rdy(bus_rdy),
        .bus_uo(bus_uo),
        .bus_uio_out(bus_uio_out),
        .bus_uio_oe(bus_uio_oe),
        .bus_uio_in(bus_uio_in),
        .bus_phase(bus_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0000;
        mem_req    = 1'b0;
        mem_addr   = 16'h0000;
        mem_we     = 1'b0;
        mem_wdata  = 8'h00;
        bus_rdy    = 1'b1;
        bus_uio_in = 8'h00;
        step();
        step();
        rst = 1'b0;
        chk("rst_phase", 32'(bus_phase), 0);
        chk("rst_oe", 32'(bus_uio_oe), 0);
        chk("rst_gnt", 32'({fetch_gnt, mem_gnt}), 0);
        chk("rst_done", 32'({fetch_done, mem_done, bus_err}), 0);
        chk("rst_rdata", 32'(rdata), 0);

        // 1: fetch read
        fetch_req  = 1'b1;
        fetch_addr = 16'h1234;
        bus_uio_in = 8'hA9;
        step();
        chk("t1_ph1", 32'(bus_phase), 1);
        chk("t1_uo1", 32'(bus_uo), 'h34);
        chk("t1_oe1", 32'(bus_uio_oe), 'h01);
        chk("t1_gnt", 32'({fetch_gnt, mem_gnt}), 'b10);
        step();
        chk("t1_ph2", 32'(bus_phase), 2);
        chk("t1_uo2", 32'(bus_uo), 'h12);
        chk("t1_oe2", 32'(bus_uio_oe), 'h01);
        step();
        chk("t1_ph3", 32'(bus_phase), 3);
        chk("t1_uo3", 32'(bus_uo), 'h34);
        chk("t1_oe3", 32'(bus_uio_oe), 'h00);
        step();
        chk("t1_done", 32'({fetch_done, mem_done, bus_err}), 'b100);
        chk("t1_rdata", 32'(rdata), 'hA9);
        chk("t1_gnt0", 32'(fetch_gnt), 0);
        chk("t1_ph0", 32'(bus_phase), 0);
        fetch_req = 1'b0;
        step();
        chk("t1_pulse", 32'(fetch_done), 0);

        // 2: mem write
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 16'h00FF;
        mem_wdata = 8'h5A;
        step();
        chk("t2_uo1", 32'(bus_uo), 'hFF);
        chk("t2_uio1", 32'(bus_uio_out), 'h01);
        chk("t2_gnt", 32'({fetch_gnt, mem_gnt}), 'b01);
        step();
        chk("t2_uo2", 32'(bus_uo), 'h00);
        chk("t2_uio2", 32'(bus_uio_out), 'h01);
        step();
        chk("t2_oe3", 32'(bus_uio_oe), 'hFF);
        chk("t2_uio3", 32'(bus_uio_out), 'h5A);
        step();
        chk("t2_done", 32'({fetch_done, mem_done, bus_err}), 'b010);
        chk("t2_rdata", 32'(rdata), 'hA9);
        chk("t2_oe0", 32'(bus_uio_oe), 'h00);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        step();

        // 3: both requesting, round-robin with no idle gap
        fetch_req = 1'b1;
        mem_req   = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            logic ef;
            ef = (k % 2 == 0);
            chk("t3_ph1", 32'(bus_phase), 1);
            chk("t3_gnt", 32'({fetch_gnt, mem_gnt}), 32'({ef, !ef}));
            step();
            step();
            step();
            chk("t3_done", 32'({fetch_done, mem_done}), 32'({ef, !ef}));
            chk("t3_idle", 32'(bus_phase), 0);
            if (k < 3) step();
        end
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        step();
        chk("t3_stop", 32'(bus_phase), 0);

        // 4: read with three wait states
        mem_req    = 1'b1;
        mem_addr   = 16'h0042;
        bus_rdy    = 1'b0;
        bus_uio_in = 8'h3C;
        step();
        step();
        step();
        chk("t4_d1", 32'(bus_phase), 3);
        step();
        step();
        step();
        chk("t4_d4", 32'(bus_phase), 3);
        chk("t4_nodone", 32'(mem_done), 0);
        bus_rdy = 1'b1;
        step();
        chk("t4_done", 32'({fetch_done, mem_done, bus_err}), 'b010);
        chk("t4_rdata", 32'(rdata), 'h3C);
        mem_req = 1'b0;
        step();

        // 5: timeout after sixteen DATA cycles
        fetch_req  = 1'b1;
        fetch_addr = 16'hBEEF;
        bus_rdy    = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 15; i++) begin
            chk("t5_wait", 32'(bus_phase), 3);
            chk("t5_noerr", 32'(bus_err), 0);
            step();
        end
        chk("t5_d16", 32'(bus_phase), 3);
        step();
        chk("t5_abort", 32'({fetch_done, mem_done, bus_err}), 'b101);
        chk("t5_rdata", 32'(rdata), 'hFF);
        chk("t5_ph0", 32'(bus_phase), 0);
        fetch_req = 1'b0;
        step();
        chk("t5_errpulse", 32'(bus_err), 0);
        mem_req    = 1'b1;
        bus_rdy    = 1'b1;
        bus_uio_in = 8'h77;
        step();
        step();
        step();
        step();
        chk("t5_next", 32'({fetch_done, mem_done, bus_err}), 'b010);
        chk("t5_nrdata", 32'(rdata), 'h77);
        mem_req = 1'b0;
        step();

        // 6: reset during DATA of a write
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = 8'hC3;
        step();
        step();
        step();
        chk("t6_oe", 32'(bus_uio_oe), 'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ph", 32'(bus_phase), 0);
        chk("t6_oe0", 32'(bus_uio_oe), 0);
        chk("t6_gnt", 32'({fetch_gnt, mem_gnt}), 0);
        chk("t6_nodone", 32'({fetch_done, mem_done, bus_err}), 0);
        chk("t6_rdata", 32'(rdata), 0);
        mem_we    = 1'b0;
        fetch_req = 1'b1;
        step();
        chk("t6_tie", 32'({fetch_gnt, mem_gnt}), 'b10);
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
